flat_queue_store: RTL and testbench
===================================

# flat_queue_store

Circular queue storage that holds `mem_depth` words of `mem_width` bits. It exposes the entire array as one flattened bus plus the current read pointer. It sits directly upstream of the parametric word-select mux: `data_flat` drives the mux data input and `rd_ptr` drives its address, so the mux output is always the queue head. Push and pop are synchronous; head selection is left to the downstream mux.

## Interface
- `mem_width`, 16, bits per entry
- `mem_depth`, 16, number of entries; power of two, ≥ 2
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `push_valid`  in  1  producer offers `push_data`
- `push_data`  in  `mem_width`  word to enqueue
- `push_ready`  out  1  queue can accept; equals `!full`
- `pop`  in  1  consumer takes head entry this cycle
- `pop_valid`  out  1  head entry is valid; equals `!empty`
- `flush`  in  1  discard all entries
- `data_flat`  out  `mem_width*mem_depth`  entry i at bits [(i+1)*mem_width-1 : i*mem_width]
- `rd_ptr`  out  `$clog2(mem_depth)`  index of head entry; feeds mux address
- `wr_ptr`  out  `$clog2(mem_depth)`  index of next write slot
- `count`  out  `$clog2(mem_depth)+1`  occupied entries, 0..mem_depth
- `full`  out  1  `count == mem_depth`
- `empty`  out  1  `count == 0`
- `overflow_err`  out  1  sticky: push attempted while full
- `underflow_err`  out  1  sticky: pop attempted while empty

## Operation
- **Storage:** `mem_depth` registers; `data_flat` is their direct concatenation, with no output logic beyond wiring.
- **Push accept:** `push_valid && !full && !flush`.
  - Writes `push_data` into entry `wr_ptr`.
  - `wr_ptr` increments modulo `mem_depth`.
- **Pop accept:** `pop && !empty && !flush`.
  - `rd_ptr` increments modulo `mem_depth`.
  - Entry contents are unchanged.
- **Count:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- **Pointer wrap:** pointers are `$clog2(mem_depth)` bits and wrap naturally from `mem_depth-1` to 0. Full and empty are derived from `count`, not pointer compare.
- **Full:** push is rejected even if a pop is accepted in the same cycle (no pass-through). The pop proceeds normally.
- **Empty:** pop is ignored. A simultaneous push is accepted. There is no bypass; data becomes poppable the following cycle.
- **Flush:** has priority over push and pop.
  - `rd_ptr`, `wr_ptr` and `count` are set to 0.
  - Storage contents are retained.
  - Error flags are unaffected.
- **overflow_err:** sets on `push_valid && full && !flush`. Cleared only by reset.
- **underflow_err:** sets on `pop && empty && !flush`. Cleared only by reset.
- **Reset:** has priority over flush.
  - All storage entries cleared to 0.
  - `rd_ptr` = `wr_ptr` = `count` = 0.
  - `empty` = 1, `full` = 0, `push_ready` = 1, `pop_valid` = 0.
  - `overflow_err` = `underflow_err` = 0.
  - `data_flat` = 0.

## Timing
- All outputs are registered state or trivial decodes of `count`.
  - No combinational path from `push_valid`, `pop` or `flush` to any output.
  - `push_ready` and `pop_valid` depend only on `count`.
- **Push latency:** a word accepted at edge N appears in `data_flat` and is counted after edge N. `pop_valid` can rise in cycle N+1.
- **Pop:** the head word is valid at the mux output while `pop_valid`=1. Asserting `pop` advances `rd_ptr` at the next edge, and the new head is visible that cycle via the mux.
- **Sustained throughput:** 1 push and 1 pop per cycle when `0 < count < mem_depth`.
- **Reset or flush mid-operation:** takes effect at the asserting edge. Any push or pop in that cycle is discarded and does not alter storage or pointers.

## Test plan
1. **Reset state.** Stimulus: `mem_width`=16, `mem_depth`=4, reset high 2 cycles. Required: `data_flat`=0, `count`=0, `empty`=1, `push_ready`=1, both error flags 0.
2. **Fill and drain.** Stimulus: push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
   - After fill: `full`=1, `count`=4, `data_flat`=0x4444_3333_2222_1111, `rd_ptr`=0.
   - Then pop 4 cycles. Mux outputs 0x1111, 0x2222, 0x3333, 0x4444 in order, then `empty`=1.
3. **Wrap and concurrency.** Stimulus: push 3 words, pop 2, then 6 cycles of simultaneous push+pop. Required:
   - `count` holds at 1 throughout the concurrent phase.
   - Pointers wrap 3→0.
   - Head order matches push order.
4. **Full and empty rejection.** Stimulus: at `count`=4, push 0xAAAA together with pop.
   - `count`=3, entry unchanged, `overflow_err`=1.
   - Then drain to empty and pop again: `count` stays 0 and `underflow_err`=1.
5. **Flush priority.** Stimulus: at `count`=2, assert flush with push 0xBEEF and pop in the same cycle.
   - Next cycle: `count`=0, both pointers 0, no 0xBEEF written, error flags unchanged.
6. **Reset mid-stream.** Stimulus: assert reset during a push of 0x5555 at `count`=3. Required: full reset state next cycle, `data_flat`=0.

Source files
------------

// File: rtl/flat_queue_store.sv
// Circular queue storage exposing the whole array as one flat bus plus head/tail pointers.
// Head selection is done by a downstream word-select mux driven by data_flat and rd_ptr.
module flat_queue_store #(
   parameter int mem_width = 16,
   parameter int mem_depth = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push_valid,
   input  logic [mem_width-1:0]             push_data,
   output logic                             push_ready,
   input  logic                             pop,
   output logic                             pop_valid,
   input  logic                             flush,
   output logic [mem_width*mem_depth-1:0]   data_flat,
   output logic [$clog2(mem_depth)-1:0]     rd_ptr,
   output logic [$clog2(mem_depth)-1:0]     wr_ptr,
   output logic [$clog2(mem_depth):0]       count,
   output logic                             full,
   output logic                             empty,
   output logic                             overflow_err,
   output logic                             underflow_err
);

   localparam int ptr_w = $clog2(mem_depth);
   localparam logic [ptr_w:0] count_max = (ptr_w+1)'(mem_depth);
   localparam logic [ptr_w:0] count_one = (ptr_w+1)'(1);
   localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);

   logic push_acc;
   logic pop_acc;

   assign full       = (count == count_max);
   assign empty      = (count == '0);
   assign push_ready = !full;
   assign pop_valid  = !empty;

   always_comb begin
      push_acc = push_valid && !full && !flush;
      pop_acc  = pop && !empty && !flush;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_flat     <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (push_valid && full && !flush)
            overflow_err <= 1'b1;
         if (pop && empty && !flush)
            underflow_err <= 1'b1;

         // Flush clears only bookkeeping; stored words stay in place.
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_acc) begin
               data_flat[int'(wr_ptr)*mem_width +: mem_width] <= push_data;
               wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop_acc)
               rd_ptr <= rd_ptr + ptr_one;
            if (push_acc && !pop_acc)
               count <= count + count_one;
            else if (pop_acc && !push_acc)
               count <= count - count_one;
         end
      end
   end

endmodule

// File: tb/tb_flat_queue_store.sv
// Randomized and directed bench for flat_queue_store against a queue-based reference model.
module tb_flat_queue_store;

   localparam int W = 16;
   localparam int D = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              push_valid;
   logic [W-1:0]      push_data;
   logic              push_ready;
   logic              pop;
   logic              pop_valid;
   logic              flush;
   logic [W*D-1:0]    data_flat;
   logic [1:0]        rd_ptr;
   logic [1:0]        wr_ptr;
   logic [2:0]        count;
   logic              full;
   logic              empty;
   logic              overflow_err;
   logic              underflow_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] m_mem [D];
   logic [W-1:0] m_q [$];
   int           m_rd, m_wr;
   bit           m_ovf, m_unf;

   always #5 clk = ~clk;

   flat_queue_store #(.mem_width(W), .mem_depth(D)) dut (
      .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
      .push_ready(push_ready), .pop(pop), .pop_valid(pop_valid), .flush(flush),
      .data_flat(data_flat), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .count(count),
      .full(full), .empty(empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit pv, input logic [W-1:0] d, input bit p, input bit f);
      int n;
      bit pa, qa;
      n = m_q.size();
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_q.delete();
         m_rd = 0; m_wr = 0; m_ovf = 0; m_unf = 0;
      end else begin
         if (pv && n == D && !f) m_ovf = 1;
         if (p && n == 0 && !f) m_unf = 1;
         if (f) begin
            m_q.delete();
            m_rd = 0; m_wr = 0;
         end else begin
            pa = pv && n < D;
            qa = p && n > 0;
            if (qa) begin
               void'(m_q.pop_front());
               m_rd = (m_rd + 1) % D;
            end
            if (pa) begin
               m_mem[m_wr] = d;
               m_q.push_back(d);
               m_wr = (m_wr + 1) % D;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [W*D-1:0] flat;
      logic [W*D-1:0] snap;
      int n;
      n = m_q.size();
      for (int i = 0; i < D; i++) flat[i*W +: W] = m_mem[i];
      check("count", 64'(count), 64'(n));
      check("rd_ptr", 64'(rd_ptr), 64'(m_rd));
      check("wr_ptr", 64'(wr_ptr), 64'(m_wr));
      check("full", 64'(full), 64'(n == D));
      check("empty", 64'(empty), 64'(n == 0));
      check("push_ready", 64'(push_ready), 64'(n != D));
      check("pop_valid", 64'(pop_valid), 64'(n != 0));
      check("overflow_err", 64'(overflow_err), 64'(m_ovf));
      check("underflow_err", 64'(underflow_err), 64'(m_unf));
      check("data_flat", 64'(data_flat), 64'(flat));
      if (n > 0) begin
         snap = data_flat;
         check("mux_head", 64'(snap[int'(rd_ptr)*W +: W]), 64'(m_q[0]));
      end
   endtask

   task automatic step(input bit r, input bit pv, input logic [W-1:0] d, input bit p, input bit f);
      reset = r; push_valid = pv; push_data = d; pop = p; flush = f;
      @(posedge clk);
      model_update(r, pv, d, p, f);
      #1;
      compare_all();
   endtask

   function automatic logic [W-1:0] head_word();
      logic [W*D-1:0] snap;
      snap = data_flat;
      return snap[int'(rd_ptr)*W +: W];
   endfunction

   initial begin
      logic [W-1:0] exp_head [4];
      exp_head[0] = 16'h1111; exp_head[1] = 16'h2222;
      exp_head[2] = 16'h3333; exp_head[3] = 16'h4444;

      reset = 1; push_valid = 0; push_data = '0; pop = 0; flush = 0;
      m_rd = 0; m_wr = 0;

      // 1. reset state
      step(1, 0, '0, 0, 0);
      step(1, 0, '0, 0, 0);
      check("rst_data_flat", 64'(data_flat), 64'h0);
      check("rst_empty", 64'(empty), 64'h1);

      // 2. fill and drain
      for (int i = 0; i < 4; i++) step(0, 1, exp_head[i], 0, 0);
      check("fill_flat", 64'(data_flat), 64'h4444_3333_2222_1111);
      check("fill_full", 64'(full), 64'h1);
      for (int i = 0; i < 4; i++) begin
         check("drain_head", 64'(head_word()), 64'(exp_head[i]));
         step(0, 0, '0, 1, 0);
      end
      check("drain_empty", 64'(empty), 64'h1);

      // 3. wrap and concurrency
      for (int i = 0; i < 3; i++) step(0, 1, 16'(16'hA000 + i), 0, 0);
      for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 16'(16'hC000 + i), 1, 0);
         check("conc_count", 64'(count), 64'h1);
      end

      // 4. full and empty rejection
      for (int i = 0; i < 3; i++) step(0, 1, 16'(16'hD000 + i), 0, 0);
      check("pre_full", 64'(count), 64'h4);
      step(0, 1, 16'hAAAA, 1, 0);
      check("ovf_count", 64'(count), 64'h3);
      check("ovf_flag", 64'(overflow_err), 64'h1);
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
      step(0, 0, '0, 1, 0);
      check("unf_count", 64'(count), 64'h0);
      check("unf_flag", 64'(underflow_err), 64'h1);

      // 5. flush priority
      step(0, 1, 16'h0101, 0, 0);
      step(0, 1, 16'h0202, 0, 0);
      step(0, 1, 16'hBEEF, 1, 1);
      check("flush_count", 64'(count), 64'h0);
      check("flush_rd", 64'(rd_ptr), 64'h0);
      check("flush_wr", 64'(wr_ptr), 64'h0);

      // 6. reset mid-stream
      for (int i = 0; i < 3; i++) step(0, 1, 16'(16'hE000 + i), 0, 0);
      step(1, 1, 16'h5555, 0, 0);
      check("midrst_flat", 64'(data_flat), 64'h0);
      check("midrst_errs", 64'({overflow_err, underflow_err}), 64'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit r, pv, p, f;
         r  = ($urandom_range(0, 99) < 2);
         f  = ($urandom_range(0, 99) < 4);
         pv = ($urandom_range(0, 99) < 55);
         p  = ($urandom_range(0, 99) < 45);
         step(r, pv, 16'($urandom), p, f);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
